usb_tx_packer: RTL and testbench
================================

Name: usb_tx_packer

Overview:
- Byte-level USB transmit packet assembler, directly downstream of the IN protocol engine.
- Accepts the engine's packet-begin strobe, PID and pull-style data stream.
- Emits a framed byte stream (PID byte, payload, CRC16) to the bit-level NRZI/bit-stuff serializer over a valid/ready handshake.
- Returns the end-of-packet strobe to the engine.

Parameters:
- MAX_IN_PACKET_SIZE, 32: payload byte cap per packet; must be in {8,16,32}.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_rst  input  1  reset, synchronous, active-high.
- i_txPktBegin  input  1  strobe: start a packet; i_txPid is valid in this cycle.
- i_txPid  input  4  PID to send, sampled only with i_txPktBegin.
- i_txDataAvail  input  1  engine has another payload byte.
- o_txDataGet  output  1  pull strobe; the byte is sampled from i_txData in the same cycle.
- i_txData  input  8  payload byte.
- o_txPktEnd  output  1  one-cycle strobe: packet fully handed to the serializer.
- o_byteValid  output  1  o_byte/o_byteLast valid.
- i_byteReady  input  1  serializer accepts the byte when high together with o_byteValid.
- o_byte  output  8  byte to the serializer, LSB transmitted first.
- o_byteLast  output  1  marks the final byte of the packet.
- o_busy  output  1  packet in progress (FSM not in IDLE).

Behaviour:
- Reset values: all outputs 0. FSM = IDLE, CRC register = 16'hFFFF, byte count = 0.
- FSM states: IDLE, PID, DATA_REQ, DATA_SEND, CRC_LO, CRC_HI, END.
- IDLE:
  - On i_txPktBegin with i_txPid != 4'b0000: capture pid, CRC := FFFF, count := 0, go to PID.
  - PID 4'b0000 is ignored: stay in IDLE, no o_txPktEnd.
- PID: o_byte = {~pid, pid}, o_byteValid = 1.
  - o_byteLast = 1 unless pid[1:0] == 2'b11 (DATA PID).
  - On accept: go to DATA_REQ for DATA PIDs, otherwise go to END.
- DATA_REQ (valid low):
  - If count == MAX_IN_PACKET_SIZE: go to CRC_LO without pulling.
  - Else if i_txDataAvail: assert o_txDataGet for one cycle, register i_txData, go to DATA_SEND.
  - Else: go to CRC_LO.
- o_txDataGet is never asserted in two consecutive cycles, nor in the cycle after i_txPktBegin. The engine's registered buffer read requires this gap.
- DATA_SEND: o_byte = registered byte, valid = 1, last = 0. On accept: update CRC with the byte, count += 1, go to DATA_REQ.
- CRC16 (USB):
  - Reflected polynomial 0xA001, LSB-first, init FFFF.
  - Transmitted value = ~CRC.
  - CRC_LO sends the low byte; CRC_HI sends the high byte with o_byteLast = 1.
- END: o_txPktEnd = 1 for exactly one cycle, then IDLE. Earliest next i_txPktBegin is accepted in the cycle after END.
- Handshake rules:
  - o_byte and o_byteLast stay stable while o_byteValid && !i_byteReady.
  - o_byteValid does not drop before acceptance.
  - i_byteReady with valid low has no effect.
- Back-to-back: a byte is accepted in cycle t, and the next state's byte may be valid in t+1.
- i_txPktBegin while busy: ignored; the packet in progress is unaffected.
- Cap boundary: MAX_IN_PACKET_SIZE bytes are sent, then CRC follows even if i_txDataAvail is still high. No extra get is issued.
- Zero-length DATA packet: PID followed by CRC bytes 00 00.
- i_rst mid-packet: immediate return to IDLE. Valid drops the next cycle and no o_txPktEnd is generated.
- Count width: $clog2(MAX_IN_PACKET_SIZE)+1 bits; it cannot wrap.

Test Plan:
- NAK handshake: begin with pid 1010, ready tied 1 -> single byte 5A with last=1, no o_txDataGet, o_txPktEnd 1 cycle after accept. Repeat for STALL (1E) and ACK (D2).
- Zero-length DATA1: pid 1011, avail=0 -> bytes 4B, 00, 00 with last on the third byte, exactly one pktEnd.
- Payload CRC: DATA0 with payload 31..39 (9 bytes, "123456789") -> bytes C3, 31..39, C8, B4. Exactly 9 get pulses, none in consecutive cycles.
- Backpressure: same packet with i_byteReady random 30% duty -> identical byte sequence, o_byte stable while stalled, no dropped or duplicated bytes.
- Cap: MAX_IN_PACKET_SIZE=8, avail held high with 12 bytes queued -> exactly 8 gets, then 2 CRC bytes, last on the final CRC byte.
- Reset/abuse: assert i_rst during the 4th payload byte -> o_byteValid=0 and o_busy=0 next cycle, no pktEnd. A begin strobe during a packet is ignored. A begin with pid 0000 produces no output.

Source files
------------

// File: rtl/usb_tx_packer.sv
// USB transmit byte packer: frames PID, pulled payload and CRC16 into a
// valid/ready byte stream for the bit-level serializer.
module usb_tx_packer #(
  parameter int MAX_IN_PACKET_SIZE = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_txPktBegin,
  input  logic [3:0] i_txPid,
  input  logic       i_txDataAvail,
  output logic       o_txDataGet,
  input  logic [7:0] i_txData,
  output logic       o_txPktEnd,
  output logic       o_byteValid,
  input  logic       i_byteReady,
  output logic [7:0] o_byte,
  output logic       o_byteLast,
  output logic       o_busy
);

  localparam int CW = $clog2(MAX_IN_PACKET_SIZE) + 1;
  localparam logic [CW-1:0] CAP = CW'(MAX_IN_PACKET_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_DATA_REQ, S_DATA_SEND, S_CRC_LO, S_CRC_HI, S_END
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_pid;
  logic [15:0]     r_crc;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_data;
  logic            w_isData;
  logic            w_start;

  // Reflected USB CRC16 (poly 0xA001), one byte processed LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign w_isData = (r_pid[1:0] == 2'b11);
  assign w_start  = (r_state == S_IDLE) && i_txPktBegin && (i_txPid != 4'b0000);
  assign o_busy   = (r_state != S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pid   <= 4'h0;
      r_crc   <= 16'hFFFF;
      r_count <= '0;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_pid   <= i_txPid;
        r_crc   <= 16'hFFFF;
        r_count <= '0;
      end
      if (o_txDataGet) begin
        r_data <= i_txData;
      end
      if ((r_state == S_DATA_SEND) && i_byteReady) begin
        r_crc   <= crc16_byte(r_crc, r_data);
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Pulls only happen from DATA_REQ, which is always separated by DATA_SEND,
  // so the engine never sees back-to-back get strobes.
  always_comb begin
    w_next      = r_state;
    o_byteValid = 1'b0;
    o_byte      = 8'h00;
    o_byteLast  = 1'b0;
    o_txDataGet = 1'b0;
    o_txPktEnd  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_next = S_PID;
      end
      S_PID: begin
        o_byteValid = 1'b1;
        o_byte      = {~r_pid, r_pid};
        o_byteLast  = !w_isData;
        if (i_byteReady) w_next = w_isData ? S_DATA_REQ : S_END;
      end
      S_DATA_REQ: begin
        if (r_count == CAP) begin
          w_next = S_CRC_LO;
        end else if (i_txDataAvail) begin
          o_txDataGet = 1'b1;
          w_next      = S_DATA_SEND;
        end else begin
          w_next = S_CRC_LO;
        end
      end
      S_DATA_SEND: begin
        o_byteValid = 1'b1;
        o_byte      = r_data;
        if (i_byteReady) w_next = S_DATA_REQ;
      end
      S_CRC_LO: begin
        o_byteValid = 1'b1;
        o_byte      = ~r_crc[7:0];
        if (i_byteReady) w_next = S_CRC_HI;
      end
      S_CRC_HI: begin
        o_byteValid = 1'b1;
        o_byte      = ~r_crc[15:8];
        o_byteLast  = 1'b1;
        if (i_byteReady) w_next = S_END;
      end
      S_END: begin
        o_txPktEnd = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_usb_tx_packer.sv
// Directed bench for usb_tx_packer: handshake PIDs, DATA framing/CRC,
// backpressure, payload cap, reset and abuse cases.
module tb_usb_tx_packer;

  logic       clk, rst;
  logic       begin32, begin8, avail, rdy, sel8;
  logic [3:0] pid_in;
  logic [7:0] din;
  logic       g32, e32, v32, l32, bs32;
  logic       g8, e8, v8, l8, bs8;
  logic [7:0] b32, b8;
  logic       m_get, m_end, m_valid, m_last, m_busy;
  logic [7:0] m_byte;

  int total = 0;
  int bad = 0;

  logic [7:0] src   [0:15];
  int         src_n, src_i;
  logic [7:0] cap_b [0:47];
  logic       cap_l [0:47];
  logic [7:0] exp_b [0:47];
  int         nexp, ncap, ngets, nends, acc_cyc, end_cyc;
  logic [15:0] crc_v;

  usb_tx_packer #(.MAX_IN_PACKET_SIZE(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_txPktBegin(begin32), .i_txPid(pid_in),
    .i_txDataAvail(avail), .o_txDataGet(g32), .i_txData(din), .o_txPktEnd(e32),
    .o_byteValid(v32), .i_byteReady(rdy), .o_byte(b32), .o_byteLast(l32), .o_busy(bs32)
  );

  usb_tx_packer #(.MAX_IN_PACKET_SIZE(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_txPktBegin(begin8), .i_txPid(pid_in),
    .i_txDataAvail(avail), .o_txDataGet(g8), .i_txData(din), .o_txPktEnd(e8),
    .o_byteValid(v8), .i_byteReady(rdy), .o_byte(b8), .o_byteLast(l8), .o_busy(bs8)
  );

  assign m_get   = sel8 ? g8  : g32;
  assign m_end   = sel8 ? e8  : e32;
  assign m_valid = sel8 ? v8  : v32;
  assign m_byte  = sel8 ? b8  : b32;
  assign m_last  = sel8 ? l8  : l32;
  assign m_busy  = sel8 ? bs8 : bs32;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Bit-at-a-time CRC16/USB over src[0..n-1], returned already inverted.
  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ src[i][b];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'hA001;
      end
    end
    return ~c;
  endfunction

  task automatic run_pkt(input logic [3:0] pid, input bit use8, input int rdy_pct,
                         input logic [3:0] abuse_pid, input int rst_at, input int max_cyc);
    bit         prev_get, prev_stall, done, rst_fired, strobe;
    logic [7:0] prev_byte;
    logic       prev_last;
    int         post_rst;
    ncap = 0; ngets = 0; nends = 0; acc_cyc = -1; end_cyc = -1; src_i = 0;
    prev_get = 0; prev_stall = 0; done = 0; rst_fired = 0; post_rst = 0;
    prev_byte = 8'h00; prev_last = 1'b0;
    sel8 = use8;
    for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
      @(negedge clk);
      rst     = 1'b0;
      strobe  = (cyc == 0) || (cyc == 2 && abuse_pid != 4'h0);
      begin32 = strobe && !use8;
      begin8  = strobe && use8;
      pid_in  = (cyc == 0) ? pid : ((cyc == 2) ? abuse_pid : 4'h0);
      avail   = (src_i < src_n);
      din     = (src_i < src_n) ? src[src_i] : 8'h00;
      rdy     = ($urandom_range(99) < rdy_pct);
      #1;
      if (rst_fired) begin
        if (post_rst == 0) begin
          check("rst_valid", m_valid, 0);
          check("rst_busy", m_busy, 0);
        end
        if (m_end) nends++;
        post_rst++;
        if (post_rst == 6) done = 1;
      end else begin
        if (cyc == 1) check("get_after_begin", m_get, 0);
        if (prev_stall) begin
          check("stall_valid", m_valid, 1);
          check("stall_byte", m_byte, prev_byte);
          check("stall_last", m_last, prev_last);
        end
        if (m_get) begin
          check("get_gap", prev_get, 0);
          ngets++;
          src_i++;
        end
        prev_get = m_get;
        if (rst_at >= 0 && m_valid && ncap == rst_at) begin
          rst = 1'b1;
          rst_fired = 1;
        end else if (m_valid && rdy && ncap < 48) begin
          cap_b[ncap] = m_byte;
          cap_l[ncap] = m_last;
          ncap++;
          acc_cyc = cyc;
        end
        prev_stall = m_valid && !rdy;
        prev_byte  = m_byte;
        prev_last  = m_last;
        if (m_end) begin
          nends++;
          end_cyc = cyc;
          done = 1;
        end
      end
    end
    if (!done) check("timeout", done, 1);
    begin32 = 1'b0;
    begin8  = 1'b0;
  endtask

  task automatic check_seq(input string tag, input int exp_gets);
    check({tag, "_len"}, ncap, nexp);
    for (int i = 0; i < nexp && i < ncap; i++) begin
      check({tag, "_byte"}, cap_b[i], exp_b[i]);
      check({tag, "_last"}, cap_l[i], (i == nexp - 1));
    end
    check({tag, "_gets"}, ngets, exp_gets);
    check({tag, "_ends"}, nends, 1);
    check({tag, "_endlat"}, end_cyc, acc_cyc + 1);
  endtask

  task automatic load_123456789();
    for (int i = 0; i < 9; i++) src[i] = 8'h31 + 8'(i);
    src_n = 9;
    exp_b[0] = 8'hC3;
    for (int i = 0; i < 9; i++) exp_b[i+1] = 8'h31 + 8'(i);
    exp_b[10] = 8'hC8;
    exp_b[11] = 8'hB4;
    nexp = 12;
  endtask

  initial begin
    rst = 1'b1; begin32 = 0; begin8 = 0; avail = 0; rdy = 1; sel8 = 0;
    pid_in = 4'h0; din = 8'h00; src_n = 0;
    for (int i = 0; i < 16; i++) src[i] = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid0", v32, 0);
    check("rst_busy0", bs32, 0);
    check("rst_get0", g32, 0);
    check("rst_end0", e32, 0);
    check("rst_byte0", b32, 0);
    check("rst_last0", l32, 0);
    rst = 1'b0;

    src_n = 0; nexp = 1;
    exp_b[0] = 8'h5A; run_pkt(4'b1010, 0, 100, 4'h0, -1, 40); check_seq("nak", 0);
    exp_b[0] = 8'h1E; run_pkt(4'b1110, 0, 100, 4'h0, -1, 40); check_seq("stall", 0);
    exp_b[0] = 8'hD2; run_pkt(4'b0010, 0, 100, 4'h0, -1, 40); check_seq("ack", 0);

    exp_b[0] = 8'h4B; exp_b[1] = 8'h00; exp_b[2] = 8'h00; nexp = 3;
    run_pkt(4'b1011, 0, 100, 4'h0, -1, 40); check_seq("zlp", 0);

    // Includes an ignored begin strobe mid-packet.
    load_123456789();
    run_pkt(4'b0011, 0, 100, 4'b1010, -1, 100); check_seq("crc9", 9);

    load_123456789();
    run_pkt(4'b0011, 0, 30, 4'h0, -1, 600); check_seq("bp", 9);

    for (int i = 0; i < 12; i++) src[i] = 8'hA0 + 8'(i);
    src_n = 12;
    crc_v = crc_model(8);
    exp_b[0] = 8'hC3;
    for (int i = 0; i < 8; i++) exp_b[i+1] = src[i];
    exp_b[9] = crc_v[7:0];
    exp_b[10] = crc_v[15:8];
    nexp = 11;
    run_pkt(4'b0011, 1, 100, 4'h0, -1, 100); check_seq("cap", 8);
    check("cap_avail_left", avail, 1);

    load_123456789();
    run_pkt(4'b0011, 0, 100, 4'h0, 4, 100);
    check("rst_mid_ends", nends, 0);
    check("rst_mid_bytes", ncap, 4);

    src_n = 0; nexp = 1;
    exp_b[0] = 8'hD2; run_pkt(4'b0010, 0, 100, 4'h0, -1, 40); check_seq("post_rst", 0);

    sel8 = 0;
    @(negedge clk);
    begin32 = 1'b1; pid_in = 4'b0000;
    @(negedge clk);
    begin32 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("pid0_busy", m_busy, 0);
      check("pid0_valid", m_valid, 0);
      check("pid0_end", m_end, 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
